// File: rtl/chopper_scheduler.sv
// Two-requester round-robin front end for a shared transaction chopper.
// Holds the accepted descriptor on the chopper inputs and reports one completion record per run.
module chopper_scheduler #(
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned LENGTH_WIDTH = 32,
  parameter int unsigned BLOCK_WIDTH  = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    req0_valid_i,
  output logic                    req0_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req0_address_i,
  input  logic [LENGTH_WIDTH-1:0] req0_length_i,
  input  logic [BLOCK_WIDTH-1:0]  req0_block_size_i,

  input  logic                    req1_valid_i,
  output logic                    req1_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req1_address_i,
  input  logic [LENGTH_WIDTH-1:0] req1_length_i,
  input  logic [BLOCK_WIDTH-1:0]  req1_block_size_i,

  input  logic                    abort_i,

  output logic                    chopper_enable_o,
  output logic [ADDR_WIDTH-1:0]   chopper_base_address_o,
  output logic [LENGTH_WIDTH-1:0] chopper_transfer_length_o,
  output logic [BLOCK_WIDTH-1:0]  chopper_block_size_o,
  input  logic                    chopper_fifo_write_i,
  input  logic                    chopper_fifo_last_command_i,

  output logic                    busy_o,
  output logic                    done_valid_o,
  output logic                    done_id_o,
  output logic [LENGTH_WIDTH-1:0] done_count_o,
  output logic                    done_error_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;
  localparam logic [1:0] StReject  = 2'd3;

  localparam logic [LENGTH_WIDTH-1:0] CountOne = {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]              state_q, state_d;
  logic                    prefer_q, prefer_d;  // requester that wins when both are valid
  logic                    owner_q, owner_d;
  logic [LENGTH_WIDTH-1:0] count_q, count_d;
  logic                    error_q, error_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LENGTH_WIDTH-1:0] len_q, len_d;
  logic [BLOCK_WIDTH-1:0]  blk_q, blk_d;

  logic                    idle;
  logic                    grant0, grant1;
  logic                    hs;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [LENGTH_WIDTH-1:0] sel_len;
  logic [BLOCK_WIDTH-1:0]  sel_blk;

  assign idle   = (state_q == StIdle);
  assign grant0 = req0_valid_i & (~req1_valid_i | ~prefer_q);
  assign grant1 = req1_valid_i & (~req0_valid_i |  prefer_q);

  assign req0_ready_o = idle & grant0;
  assign req1_ready_o = idle & grant1;
  assign hs           = req0_ready_o | req1_ready_o;

  always_comb begin
    if (req1_ready_o) begin
      sel_addr = req1_address_i;
      sel_len  = req1_length_i;
      sel_blk  = req1_block_size_i;
    end else begin
      sel_addr = req0_address_i;
      sel_len  = req0_length_i;
      sel_blk  = req0_block_size_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    prefer_d = prefer_q;
    owner_d  = owner_q;
    count_d  = count_q;
    error_d  = error_q;
    addr_d   = addr_q;
    len_d    = len_q;
    blk_d    = blk_q;
    case (state_q)
      StIdle: begin
        if (hs) begin
          addr_d   = sel_addr;
          len_d    = sel_len;
          blk_d    = sel_blk;
          owner_d  = req1_ready_o;
          prefer_d = ~req1_ready_o;
          count_d  = '0;
          error_d  = 1'b0;
          state_d  = ((sel_len == '0) || (sel_blk == '0)) ? StReject : StRun;
        end
      end
      StRun: begin
        if (chopper_fifo_write_i) begin
          count_d = count_q + CountOne;
        end
        // A last-flagged write completes cleanly even if abort arrives with it.
        if (chopper_fifo_write_i && chopper_fifo_last_command_i) begin
          state_d = StRelease;
          error_d = 1'b0;
        end else if (abort_i) begin
          state_d = StRelease;
          error_d = 1'b1;
        end
      end
      StRelease: state_d = StIdle;
      StReject:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      prefer_q <= 1'b0;
      owner_q  <= 1'b0;
      count_q  <= '0;
      error_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      blk_q    <= '0;
    end else begin
      state_q  <= state_d;
      prefer_q <= prefer_d;
      owner_q  <= owner_d;
      count_q  <= count_d;
      error_q  <= error_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      blk_q    <= blk_d;
    end
  end

  // Enable decodes straight from state so an asynchronous reset drops it at once.
  assign chopper_enable_o          = (state_q == StRun);
  assign chopper_base_address_o    = addr_q;
  assign chopper_transfer_length_o = len_q;
  assign chopper_block_size_o      = blk_q;

  assign busy_o       = ~idle;
  assign done_valid_o = (state_q == StRelease) | (state_q == StReject);
  assign done_id_o    = done_valid_o & owner_q;
  assign done_count_o = (state_q == StRelease) ? count_q : '0;
  assign done_error_o = (state_q == StReject) | ((state_q == StRelease) & error_q);

endmodule

// File: tb/tb_chopper_scheduler.sv
// Randomised scoreboard bench for chopper_scheduler with a behavioural chopper and requester model.
module tb_chopper_scheduler;
  localparam int unsigned AW = 64;
  localparam int unsigned LW = 32;
  localparam int unsigned BW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0v = 1'b0, r1v = 1'b0, r0r, r1r;
  logic [AW-1:0] r0a = '0, r1a = '0;
  logic [LW-1:0] r0l = '0, r1l = '0;
  logic [BW-1:0] r0b = '0, r1b = '0;
  logic          abort = 1'b0, fw = 1'b0, fl = 1'b0;
  logic          en, busy, dv, did, derr;
  logic [AW-1:0] cba;
  logic [LW-1:0] ctl, dcnt;
  logic [BW-1:0] cbs;

  always #5 clk = ~clk;

  chopper_scheduler #(.ADDR_WIDTH(AW), .LENGTH_WIDTH(LW), .BLOCK_WIDTH(BW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(r0v), .req0_ready_o(r0r), .req0_address_i(r0a),
    .req0_length_i(r0l), .req0_block_size_i(r0b),
    .req1_valid_i(r1v), .req1_ready_o(r1r), .req1_address_i(r1a),
    .req1_length_i(r1l), .req1_block_size_i(r1b),
    .abort_i(abort),
    .chopper_enable_o(en), .chopper_base_address_o(cba),
    .chopper_transfer_length_o(ctl), .chopper_block_size_o(cbs),
    .chopper_fifo_write_i(fw), .chopper_fifo_last_command_i(fl),
    .busy_o(busy), .done_valid_o(dv), .done_id_o(did),
    .done_count_o(dcnt), .done_error_o(derr)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    logic [23:0] blk;
    int          abort_after;  // abort once this many writes were issued (-1: never)
    bit          coinc;        // raise abort together with the last write
  } desc_t;

  typedef struct {
    bit          id;
    logic [31:0] cnt;
    bit          err;
  } rec_t;

  desc_t run_q[$];
  rec_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    pref = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic desc_t mk(input logic [63:0] a, input logic [31:0] l, input logic [23:0] b,
                               input int ab, input bit co);
    desc_t d;
    d.addr = a; d.len = l; d.blk = b; d.abort_after = ab; d.coinc = co;
    return d;
  endfunction

  function automatic bit is_reject(input desc_t d);
    return (d.len == 0) || (d.blk == 0);
  endfunction

  function automatic int nbeats(input desc_t d);
    longint unsigned n;
    n = (longint'(d.len) + longint'(d.blk) - 1) / longint'(d.blk);
    return int'(n);
  endfunction

  function automatic rec_t expect_of(input int r, input desc_t d);
    rec_t e;
    int n;
    e.id = (r != 0);
    if (is_reject(d)) begin
      e.cnt = 0; e.err = 1'b1;
    end else begin
      n = nbeats(d);
      if (!d.coinc && d.abort_after >= 0 && d.abort_after < n) begin
        e.cnt = d.abort_after; e.err = 1'b1;
      end else begin
        e.cnt = n; e.err = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic desc_t rnd_desc();
    desc_t d;
    int k;
    d.addr = {$urandom, $urandom};
    d.blk  = 24'($urandom_range(1, 64));
    d.len  = $urandom_range(1, 32'(d.blk) * 8);
    k = $urandom_range(0, 9);
    if (k == 0) d.len = 0;
    else if (k == 1) d.blk = 0;
    d.abort_after = -1;
    d.coinc = 1'b0;
    k = $urandom_range(0, 9);
    if (k < 2) d.abort_after = $urandom_range(0, 7);
    else if (k == 2) d.coinc = 1'b1;
    return d;
  endfunction

  // Present one descriptor, hold it until accepted, then scramble the source fields.
  task automatic issue(input int r, input desc_t d);
    bit hs = 1'b0;
    int t = 0;
    @(posedge clk); #1;
    if (r == 0) begin r0v = 1'b1; r0a = d.addr; r0l = d.len; r0b = d.blk; end
    else        begin r1v = 1'b1; r1a = d.addr; r1l = d.len; r1b = d.blk; end
    while (!hs && t < 5000) begin
      @(negedge clk);
      if ((r == 0) ? r0r : r1r) hs = 1'b1;
      else t++;
    end
    if (hs) begin
      exp_q.push_back(expect_of(r, d));
      if (!is_reject(d)) run_q.push_back(d);
    end else begin
      check("handshake_timeout", 64'd0, 64'd1);
    end
    @(posedge clk); #1;
    if (r == 0) begin r0v = 1'b0; r0a = {$urandom, $urandom}; r0l = $urandom; r0b = 24'($urandom); end
    else        begin r1v = 1'b0; r1a = {$urandom, $urandom}; r1l = $urandom; r1b = 24'($urandom); end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(t < 3000), 64'd1);
  endtask

  // Round-robin reference: favour the requester not granted last.
  bit e0, e1;
  always @(negedge clk) begin
    if (!rst_n) begin
      pref = 1'b0;
    end else begin
      e0 = !busy && r0v && (!r1v || !pref);
      e1 = !busy && r1v && (!r0v || pref);
      check("req0_ready", 64'(r0r), 64'(e0));
      check("req1_ready", 64'(r1r), 64'(e1));
      if (r0v && r0r) pref = 1'b1;
      else if (r1v && r1r) pref = 1'b0;
    end
  end

  // Completion monitor: pops the scoreboard whenever done_valid is seen.
  bit   prev_dv = 1'b0;
  rec_t got_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dv = 1'b0;
    end else begin
      if (dv) begin
        check("done_single_cycle", 64'(prev_dv), 64'd0);
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'd1, 64'd0);
        end else begin
          got_e = exp_q.pop_front();
          check("done_id", 64'(did), 64'(got_e.id));
          check("done_count", 64'(dcnt), 64'(got_e.cnt));
          check("done_error", 64'(derr), 64'(got_e.err));
        end
      end
      prev_dv = dv;
    end
  end

  // Behavioural chopper: ceil(length/block) writes after each enable rising edge.
  initial begin
    bit    active = 1'b0, prev_en = 1'b0;
    desc_t cur;
    int    done_w = 0, nb = 0, low_cnt = 99;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0; prev_en = 1'b0; low_cnt = 99;
        fw = 1'b0; fl = 1'b0; abort = 1'b0;
        continue;
      end
      if (en && !prev_en) begin
        check("enable_low_gap", 64'(low_cnt >= 2), 64'd1);
        if (run_q.size() == 0) begin
          check("enable_unexpected", 64'd1, 64'd0);
          active = 1'b0;
        end else begin
          cur = run_q.pop_front();
          active = 1'b1; done_w = 0; nb = nbeats(cur);
        end
      end
      if (en) low_cnt = 0;
      else low_cnt++;
      prev_en = en;
      if (en && active) begin
        check("hold_address", cba, cur.addr);
        check("hold_length", 64'(ctl), 64'(cur.len));
        check("hold_block", 64'(cbs), 64'(cur.blk));
        if (!cur.coinc && cur.abort_after == done_w) begin
          fw = 1'b0; fl = 1'b0; abort = 1'b1; active = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          done_w++;
          fw = 1'b1; fl = (done_w == nb); abort = fl && cur.coinc;
          if (fl) active = 1'b0;
        end else begin
          fw = 1'b0; fl = 1'($urandom_range(0, 1)); abort = 1'b0;
        end
      end else if (en) begin
        fw = 1'b0; fl = 1'b0; abort = 1'b0;
      end else begin
        // Noise while not running must have no effect.
        fw = ($urandom_range(0, 3) == 0);
        fl = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_enable", 64'(en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_valid", 64'(dv), 64'd0);
    check("rst_address", cba, 64'd0);
    #22 rst_n = 1'b1;

    // Contention from reset: order req0, req1, req0, req1.
    fork
      begin
        issue(0, mk(64'h2000, 512, 256, -1, 0));
        issue(0, mk(64'h3000, 512, 256, -1, 0));
      end
      begin
        issue(1, mk(64'h4000, 512, 256, -1, 0));
        issue(1, mk(64'h5000, 512, 256, -1, 0));
      end
    join
    drain();

    issue(0, mk(64'h1000, 1000, 256, -1, 0));
    drain();
    issue(1, mk(64'h6000, 0, 256, -1, 0));
    issue(1, mk(64'h7000, 512, 0, -1, 0));
    drain();
    issue(0, mk(64'h8000, 4096, 256, 3, 0));
    issue(1, mk(64'h9000, 300, 100, -1, 0));
    drain();
    issue(1, mk(64'hA000, 768, 256, -1, 1));
    drain();

    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(0, rnd_desc());
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(1, rnd_desc());
      end
    join
    drain();

    // Reset in the middle of a long run.
    begin
      int t = 0;
      issue(0, mk(64'hB000, 4096, 1, -1, 0));
      while (!en && t < 100) begin @(negedge clk); t++; end
      check("long_run_enable", 64'(en), 64'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("midrst_enable", 64'(en), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done_valid", 64'(dv), 64'd0);
      check("midrst_address", cba, 64'd0);
      check("midrst_length", 64'(ctl), 64'd0);
      check("midrst_block", 64'(cbs), 64'd0);
      check("midrst_done_count", 64'(dcnt), 64'd0);
      exp_q.delete();
      run_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end

    fork
      issue(0, mk(64'hC000, 200, 64, -1, 0));
      issue(1, mk(64'hD000, 200, 64, -1, 0));
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chopper_scheduler.md
Name: chopper_scheduler

Overview:
- Two-requester round-robin scheduler that shares one transaction chopper between descriptor sources, e.g. a read test generator and a write test generator.
- Accepts a descriptor (base address, transfer length, block size) from the winning requester and holds it constant on the chopper inputs.
- Drives the chopper enable and watches the chopper's FIFO write and last-command outputs to detect completion.
- Returns a per-descriptor completion record: id, command count, error.

Parameters:
ADDR_WIDTH, 64, base address width
LENGTH_WIDTH, 32, transfer length width; also the width of the completion command count
BLOCK_WIDTH, 24, block size width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 descriptor valid
req0_ready  out  1  requester 0 descriptor accepted
req0_address  in  ADDR_WIDTH  requester 0 base address
req0_length  in  LENGTH_WIDTH  requester 0 transfer length in bytes
req0_block_size  in  BLOCK_WIDTH  requester 0 block size in bytes
req1_valid, req1_ready, req1_address, req1_length, req1_block_size  same as requester 0
abort  in  1  terminate the descriptor currently running
chopper_enable  out  1  chopper enable; the chopper initializes on its rising edge
chopper_base_address  out  ADDR_WIDTH  held descriptor address
chopper_transfer_length  out  LENGTH_WIDTH  held descriptor length
chopper_block_size  out  BLOCK_WIDTH  held descriptor block size
chopper_fifo_write  in  1  chopper FIFO write strobe
chopper_fifo_last_command  in  1  chopper last-command flag
busy  out  1  state other than IDLE
done_valid  out  1  one-cycle completion pulse
done_id  out  1  requester that owned the completed descriptor
done_count  out  LENGTH_WIDTH  commands written for the completed descriptor
done_error  out  1  descriptor was rejected or aborted

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer favours requester 0. Reset asserted mid-RUN clears chopper_enable immediately (asynchronous).
- States: IDLE, RUN, RELEASE, REJECT.
- IDLE arbitration:
  - If only one req_valid is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - reqN_ready is asserted combinationally for the winner only and only in IDLE.
  - Handshake is valid & ready. On the handshake edge: descriptor registered into the chopper_* holding registers, done_id captured, command counter cleared, pointer updated.
  - Next state is REJECT if length == 0 or block_size == 0; otherwise RUN.
- RUN:
  - chopper_enable = 1; chopper_* outputs stay constant.
  - Each cycle with chopper_fifo_write = 1 increments the command counter (wraps modulo 2^LENGTH_WIDTH).
  - chopper_fifo_write & chopper_fifo_last_command -> RELEASE with error 0. That beat is counted.
  - Otherwise abort = 1 -> RELEASE with error 1.
  - If last-command and abort occur in the same cycle, normal completion wins (error 0).
- RELEASE:
  - chopper_enable = 0.
  - done_valid = 1 for exactly one cycle, with done_count = counter value and done_error per the cause above.
  - Next state is IDLE.
- REJECT: chopper_enable stays 0; done_valid = 1, done_error = 1, done_count = 0; next state IDLE.
- Enable spacing: chopper_enable is low for at least 2 cycles between descriptors (RELEASE + IDLE handshake cycle). This guarantees a fresh rising edge, and therefore chopper re-initialization, for every descriptor.
- Latency: handshake edge -> chopper_enable high 1 cycle later. Final chopper write -> done_valid on the next cycle.
- chopper_* address/length/block outputs hold their last values in IDLE and change only on a handshake.
- Requesters must not change descriptor fields while valid is high and not yet accepted. Accepted fields are registered, so later source changes are ignored.
- abort outside RUN is ignored.

Test Plan:
- Single descriptor: req0 address=0x1000, length=1000, block=256; bench chopper issues 4 writes, the 4th with last flag -> chopper_enable high for the full run, done_valid one cycle with id=0, count=4, error=0, chopper_enable low ≥2 cycles afterwards.
- Contention: req0 and req1 both valid from reset, each length=512, block=256 -> order is req0, req1, req0, req1. Each done_count=2; enable shows 4 distinct rising edges.
- Zero length and zero block: req1 length=0, then req1 block_size=0 -> both go to REJECT. done_error=1, done_count=0, chopper_enable never rises, ready pulses once each.
- Abort mid-run: length=4096, block=256; assert abort after 3 writes -> RELEASE with done_error=1, done_count=3. Next descriptor starts with a fresh enable edge.
- Abort coincident with a last-flagged write -> done_error=0, final beat counted.
- Reset mid-RUN: drop reset_n with chopper_enable=1 -> all outputs 0 asynchronously. After release, req0 is favoured when both requesters are valid.
